// File: rtl/bank_biu_wbuf.sv
// Write-data buffer between store-commit (sc) and the bank BIU W channel.
// Latency: sc accept to W valid is 1 cycle minimum (registered head, no fall-through).
// Backpressure: sc ready drops when DEPTH entries are held; W issue stalls at MAX_OUTST writes awaiting B.
//
// Ports:
//   clk_i, rst_i                       clock, asynchronous active-high reset
//   sc_wbuf_*                          entry input from sc (valid/ready, data, strb, set_way)
//   wbuf_biu_* / biu_wbuf_ready_i      head entry offered to the BIU W channel
//   biu_bvalid_i/bready_o/bid_i/bresp_i B response channel
//   wbuf_outst_o, wbuf_idle_o          writes awaiting B, idle status
//   wbuf_err_o, wbuf_err_id_o          sticky error flag and ID of the first error

// Generic synchronous FIFO: registered storage, head read straight from the array.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module wbuf_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: stale words are never exposed while count is 0.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
endmodule

// Write buffer top: entry FIFO, outstanding-write counter and B-channel error tracking.
// Latency: 1 cycle from sc accept to W valid; B handshake updates outst/err on the next edge.
// Backpressure: sc stalls when full; W valid held low while MAX_OUTST writes await B.
module bank_biu_wbuf #(
    parameter int DATA_WIDTH = 256,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEPTH      = 4,
    parameter int MAX_OUTST  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sc_wbuf_valid_i,
    output logic                  sc_wbuf_ready_o,
    input  logic [DATA_WIDTH-1:0] sc_wbuf_data_i,
    input  logic [STRB_WIDTH-1:0] sc_wbuf_strb_i,
    input  logic [5:0]            sc_wbuf_set_way_i,
    output logic                  wbuf_biu_valid_o,
    input  logic                  biu_wbuf_ready_i,
    output logic [DATA_WIDTH-1:0] wbuf_biu_data_o,
    output logic [STRB_WIDTH-1:0] wbuf_biu_strb_o,
    output logic [5:0]            wbuf_biu_set_way_o,
    input  logic                  biu_bvalid_i,
    output logic                  biu_bready_o,
    input  logic [ID_WIDTH-1:0]   biu_bid_i,
    input  logic [1:0]            biu_bresp_i,
    output logic [7:0]            wbuf_outst_o,
    output logic                  wbuf_idle_o,
    output logic                  wbuf_err_o,
    output logic [ID_WIDTH-1:0]   wbuf_err_id_o
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [7:0]       OUTST_CAP = 8'(MAX_OUTST);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_WIDTH-1:0] strb;
        logic [5:0]            set_way;
    } entry_t;

    entry_t           push_entry;
    entry_t           head_entry;
    logic [CNT_W-1:0] occ;
    logic [7:0]       outst;
    logic             err;
    logic [ID_WIDTH-1:0] err_id;

    logic push;
    logic pop;
    logic b_hs;
    logic err_event;

    assign sc_wbuf_ready_o  = ~rst_i & (occ != FULL_CNT);
    assign wbuf_biu_valid_o = ~rst_i & (occ != '0) & (outst < OUTST_CAP);
    assign biu_bready_o     = ~rst_i;

    assign push = sc_wbuf_valid_i & sc_wbuf_ready_o;
    assign pop  = wbuf_biu_valid_o & biu_wbuf_ready_i;
    assign b_hs = biu_bvalid_i & biu_bready_o;

    // A B with nothing outstanding is a protocol error in its own right.
    assign err_event = b_hs & ((biu_bresp_i != 2'b00) | (outst == 8'd0));

    assign push_entry = '{data: sc_wbuf_data_i, strb: sc_wbuf_strb_i, set_way: sc_wbuf_set_way_i};

    wbuf_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .head_dat (head_entry),
        .count    (occ)
    );

    // Head fields are forced to zero while reset is held; the pointers reset to
    // slot 0 whose contents may be stale.
    assign wbuf_biu_data_o    = rst_i ? '0 : head_entry.data;
    assign wbuf_biu_strb_o    = rst_i ? '0 : head_entry.strb;
    assign wbuf_biu_set_way_o = rst_i ? '0 : head_entry.set_way;

    // outst is capped by the issue throttle and floored at zero, so it never wraps.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst <= 8'd0;
        end else if (pop && !b_hs) begin
            outst <= outst + 8'd1;
        end else if (!pop && b_hs && (outst != 8'd0)) begin
            outst <= outst - 8'd1;
        end
    end

    // Sticky error; the ID is captured only for the first error event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err    <= 1'b0;
            err_id <= '0;
        end else if (err_event) begin
            err <= 1'b1;
            if (!err) err_id <= biu_bid_i;
        end
    end

    assign wbuf_outst_o  = outst;
    assign wbuf_idle_o   = (occ == '0) & (outst == 8'd0);
    assign wbuf_err_o    = err;
    assign wbuf_err_id_o = err_id;
endmodule

// File: tb/tb_bank_biu_wbuf.sv
// Directed bench for bank_biu_wbuf: DEPTH=4, MAX_OUTST=8, 256-bit beats.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Each scenario task does its own checks; one summary line closes the run.
module tb_bank_biu_wbuf;
    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         sc_valid = 1'b0;
    logic         sc_ready;
    logic [255:0] sc_data = '0;
    logic [31:0]  sc_strb = '0;
    logic [5:0]   sc_sw = '0;
    logic         biu_valid;
    logic         biu_ready = 1'b0;
    logic [255:0] biu_data;
    logic [31:0]  biu_strb;
    logic [5:0]   biu_sw;
    logic         bvalid = 1'b0;
    logic         bready;
    logic [7:0]   bid = '0;
    logic [1:0]   bresp = '0;
    logic [7:0]   outst;
    logic         idle;
    logic         err;
    logic [7:0]   err_id;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bank_biu_wbuf dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .sc_wbuf_valid_i    (sc_valid),
        .sc_wbuf_ready_o    (sc_ready),
        .sc_wbuf_data_i     (sc_data),
        .sc_wbuf_strb_i     (sc_strb),
        .sc_wbuf_set_way_i  (sc_sw),
        .wbuf_biu_valid_o   (biu_valid),
        .biu_wbuf_ready_i   (biu_ready),
        .wbuf_biu_data_o    (biu_data),
        .wbuf_biu_strb_o    (biu_strb),
        .wbuf_biu_set_way_o (biu_sw),
        .biu_bvalid_i       (bvalid),
        .biu_bready_o       (bready),
        .biu_bid_i          (bid),
        .biu_bresp_i        (bresp),
        .wbuf_outst_o       (outst),
        .wbuf_idle_o        (idle),
        .wbuf_err_o         (err),
        .wbuf_err_id_o      (err_id)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_i = 1'b1;
        #1;
        checks++; if (sc_ready !== 1'b0) begin errors++; $display("FAIL rst_sc_ready got %b exp 0", sc_ready); end
        checks++; if (biu_valid !== 1'b0) begin errors++; $display("FAIL rst_biu_valid got %b exp 0", biu_valid); end
        checks++; if (bready !== 1'b0) begin errors++; $display("FAIL rst_bready got %b exp 0", bready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle got %b exp 1", idle); end
        checks++; if (outst !== 8'd0 || err !== 1'b0 || err_id !== 8'd0) begin errors++; $display("FAIL rst_state outst %0d err %b id %h exp 0 0 00", outst, err, err_id); end
        checks++; if (biu_data !== 256'd0 || biu_strb !== 32'd0 || biu_sw !== 6'd0) begin errors++; $display("FAIL rst_head got %h %h %0d exp zeros", biu_data, biu_strb, biu_sw); end
        step(); step();
        rst_i = 1'b0;
        #1;
        checks++; if (sc_ready !== 1'b1 || bready !== 1'b1) begin errors++; $display("FAIL post_rst_ready sc %b b %b exp 1 1", sc_ready, bready); end
    endtask

    task automatic test_single();
        logic [255:0] pat;
        pat = {32{8'hA5}};
        step();
        sc_valid = 1'b1; sc_data = pat; sc_strb = 32'hFFFF_FFFF; sc_sw = 6'd9; biu_ready = 1'b1;
        #1;
        checks++; if (biu_valid !== 1'b0) begin errors++; $display("FAIL single_no_fallthru got %b exp 0", biu_valid); end
        step();
        sc_valid = 1'b0;
        #1;
        checks++; if (biu_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", biu_valid); end
        checks++; if (biu_data !== pat || biu_strb !== 32'hFFFF_FFFF || biu_sw !== 6'd9) begin errors++; $display("FAIL single_fields got %h %h %0d", biu_data, biu_strb, biu_sw); end
        step();
        #1;
        checks++; if (biu_valid !== 1'b0 || outst !== 8'd1 || idle !== 1'b0) begin errors++; $display("FAIL single_issued valid %b outst %0d idle %b exp 0 1 0", biu_valid, outst, idle); end
        bvalid = 1'b1; bid = 8'h09; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        #1;
        checks++; if (outst !== 8'd0 || idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL single_b outst %0d idle %b err %b exp 0 1 0", outst, idle, err); end
        biu_ready = 1'b0;
    endtask

    task automatic test_fill();
        biu_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sc_valid = 1'b1; sc_sw = 6'(10 + i); sc_data = {8{32'h1000_0000 + 32'(i)}}; sc_strb = 32'(i + 1);
            #1;
            checks++; if (sc_ready !== (i < 4)) begin errors++; $display("FAIL fill_ready_%0d got %b exp %b", i, sc_ready, (i < 4)); end
            step();
        end
        biu_ready = 1'b1;
        #1;
        checks++; if (biu_valid !== 1'b1 || biu_sw !== 6'd10 || sc_ready !== 1'b0) begin errors++; $display("FAIL fill_head0 valid %b sw %0d ready %b exp 1 10 0", biu_valid, biu_sw, sc_ready); end
        step();
        #1;
        checks++; if (biu_sw !== 6'd11 || sc_ready !== 1'b1) begin errors++; $display("FAIL fill_head1 sw %0d ready %b exp 11 1", biu_sw, sc_ready); end
        step();
        sc_valid = 1'b0;
        #1;
        checks++; if (biu_sw !== 6'd12 || biu_data !== {8{32'h1000_0002}} || biu_strb !== 32'd3) begin errors++; $display("FAIL fill_head2 sw %0d data %h strb %h", biu_sw, biu_data, biu_strb); end
        step();
        checks++; if (biu_sw !== 6'd13 || biu_valid !== 1'b1) begin errors++; $display("FAIL fill_head3 sw %0d valid %b exp 13 1", biu_sw, biu_valid); end
        step();
        checks++; if (biu_sw !== 6'd14 || biu_valid !== 1'b1) begin errors++; $display("FAIL fill_head4 sw %0d valid %b exp 14 1", biu_sw, biu_valid); end
        step();
        checks++; if (biu_valid !== 1'b0 || outst !== 8'd5) begin errors++; $display("FAIL fill_drained valid %b outst %0d exp 0 5", biu_valid, outst); end
        biu_ready = 1'b0;
        bvalid = 1'b1; bresp = 2'b00;
        for (int i = 0; i < 5; i++) begin bid = 8'(10 + i); step(); end
        bvalid = 1'b0;
        #1;
        checks++; if (outst !== 8'd0 || idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL fill_b outst %0d idle %b err %b exp 0 1 0", outst, idle, err); end
    endtask

    task automatic test_throttle();
        int  pushes;
        int  pops;
        bit  done;
        pushes = 0; pops = 0; done = 1'b0;
        biu_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            sc_valid = (pushes < 10); sc_sw = 6'(pushes); sc_data = {8{32'(pushes)}}; sc_strb = '1;
            #1;
            if (sc_valid && sc_ready) pushes++;
            if (biu_valid && biu_ready) pops++;
            step();
        end
        sc_valid = 1'b0;
        checks++; if (pushes != 10 || pops != 8) begin errors++; $display("FAIL thr_counts pushes %0d pops %0d exp 10 8", pushes, pops); end
        checks++; if (biu_valid !== 1'b0 || outst !== 8'd8 || sc_ready !== 1'b1) begin errors++; $display("FAIL thr_stall valid %b outst %0d ready %b exp 0 8 1", biu_valid, outst, sc_ready); end
        bvalid = 1'b1; bid = 8'h00; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        #1;
        checks++; if (biu_valid !== 1'b1 || biu_sw !== 6'd8 || outst !== 8'd7) begin errors++; $display("FAIL thr_release valid %b sw %0d outst %0d exp 1 8 7", biu_valid, biu_sw, outst); end
        step();
        checks++; if (biu_valid !== 1'b0 || outst !== 8'd8) begin errors++; $display("FAIL thr_one_pop valid %b outst %0d exp 0 8", biu_valid, outst); end
        for (int c = 0; c < 40 && !done; c++) begin
            if (idle === 1'b1) begin
                done = 1'b1;
                bvalid = 1'b0;
            end else begin
                bvalid = (outst != 8'd0);
                step();
            end
        end
        bvalid = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL thr_drain_timeout idle %b outst %0d exp idle 1", idle, outst); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL thr_err got %b exp 0", err); end
        biu_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        biu_ready = 1'b1;
        sc_valid = 1'b1; sc_sw = 6'd20;
        step();
        sc_valid = 1'b0;
        step();
        biu_ready = 1'b0;
        #1;
        checks++; if (outst !== 8'd1) begin errors++; $display("FAIL same_setup outst %0d exp 1", outst); end
        sc_valid = 1'b1; sc_sw = 6'd21;
        step();
        sc_sw = 6'd22;
        step();
        sc_sw = 6'd23; biu_ready = 1'b1; bvalid = 1'b1; bid = 8'h14; bresp = 2'b00;
        #1;
        checks++; if (biu_valid !== 1'b1 || biu_sw !== 6'd21 || sc_ready !== 1'b1) begin errors++; $display("FAIL same_pre valid %b sw %0d ready %b exp 1 21 1", biu_valid, biu_sw, sc_ready); end
        step();
        sc_valid = 1'b0; bvalid = 1'b0;
        #1;
        checks++; if (outst !== 8'd1 || biu_sw !== 6'd22) begin errors++; $display("FAIL same_pop_b outst %0d sw %0d exp 1 22", outst, biu_sw); end
        step();
        checks++; if (biu_valid !== 1'b1 || biu_sw !== 6'd23) begin errors++; $display("FAIL same_occ2 valid %b sw %0d exp 1 23", biu_valid, biu_sw); end
        step();
        checks++; if (biu_valid !== 1'b0 || outst !== 8'd3) begin errors++; $display("FAIL same_empty valid %b outst %0d exp 0 3", biu_valid, outst); end
        biu_ready = 1'b0;
        bvalid = 1'b1;
        step(); step(); step();
        bvalid = 1'b0;
        #1;
        checks++; if (outst !== 8'd0 || idle !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL same_b outst %0d idle %b err %b exp 0 1 0", outst, idle, err); end
    endtask

    task automatic test_error();
        biu_ready = 1'b1;
        sc_valid = 1'b1; sc_sw = 6'd3;
        step();
        sc_sw = 6'd5;
        step();
        sc_valid = 1'b0;
        step(); step();
        biu_ready = 1'b0;
        checks++; if (outst !== 8'd2) begin errors++; $display("FAIL err_setup outst %0d exp 2", outst); end
        bvalid = 1'b1; bid = 8'h03; bresp = 2'b10;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_not_early got %b exp 0", err); end
        step();
        bid = 8'h05; bresp = 2'b11;
        #1;
        checks++; if (err !== 1'b1 || err_id !== 8'h03 || outst !== 8'd1) begin errors++; $display("FAIL err_first err %b id %h outst %0d exp 1 03 1", err, err_id, outst); end
        step();
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        checks++; if (err !== 1'b1 || err_id !== 8'h03 || outst !== 8'd0) begin errors++; $display("FAIL err_held err %b id %h outst %0d exp 1 03 0", err, err_id, outst); end
    endtask

    task automatic test_async_reset();
        biu_ready = 1'b1;
        sc_valid = 1'b1; sc_sw = 6'd30; sc_data = '1;
        step();
        sc_sw = 6'd31;
        step();
        sc_valid = 1'b0;
        step(); step();
        biu_ready = 1'b0;
        sc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin sc_sw = 6'(40 + i); step(); end
        sc_valid = 1'b0;
        #1;
        checks++; if (outst !== 8'd2 || biu_valid !== 1'b1 || biu_sw !== 6'd40) begin errors++; $display("FAIL ar_setup outst %0d valid %b sw %0d exp 2 1 40", outst, biu_valid, biu_sw); end
        #2 rst_i = 1'b1;
        #1;
        checks++; if (biu_valid !== 1'b0 || sc_ready !== 1'b0 || bready !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL ar_outputs valid %b ready %b bready %b idle %b exp 0 0 0 1", biu_valid, sc_ready, bready, idle); end
        checks++; if (outst !== 8'd0 || err !== 1'b0 || err_id !== 8'd0 || biu_data !== 256'd0 || biu_sw !== 6'd0) begin errors++; $display("FAIL ar_state outst %0d err %b id %h sw %0d exp zeros", outst, err, err_id, biu_sw); end
        biu_ready = 1'b1;
        step(); step();
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (biu_valid !== 1'b0) begin errors++; $display("FAIL ar_stale_%0d valid %b exp 0", c, biu_valid); end
            step();
        end
        bvalid = 1'b1; bid = 8'h2A; bresp = 2'b00;
        step();
        bvalid = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || err_id !== 8'h2A || outst !== 8'd0) begin errors++; $display("FAIL unexpected_b err %b id %h outst %0d exp 1 2a 0", err, err_id, outst); end
        biu_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_throttle();
        test_same_cycle();
        test_error();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
